// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the master FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StBusreq,
    StAddr,
    StData,
    StSplitWait,
    StResp
  } mst_state_e;

endpackage

// File: rtl/ahb_master_if_if.sv
// Command port plus AHB master-side bus signals; "master" is the DUT view.
interface ahb_master_if_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              hbusreq;
  logic              hgrant;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;
  logic              hsplit;
  logic              hsplit_done;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output hbusreq, haddr, htrans, hwrite, hwdata,
    input  hgrant, hrdata, hready, hresp, hsplit, hsplit_done
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  hbusreq, haddr, htrans, hwrite, hwdata,
    output hgrant, hrdata, hready, hresp, hsplit, hsplit_done
  );
endinterface

// File: rtl/ahb_wait_timer.sv
// Saturating cycle counter; term flags the cycle whose count reaches TIMEOUT.
module ahb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);
  localparam int unsigned    CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Max = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Max)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Looks at the next count so the abort lands on the TIMEOUT-th stalled cycle.
  assign term = (cnt_d == Max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ahb_master_if.sv
// Single-transfer AHB master: bus request, NONSEQ address, data phase with
// wait/error/split handling, one response per command.
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_SPLIT = 3
) (
  input logic              hclk,
  input logic              hresetn,
  ahb_master_if_if.master  bus
);
  localparam int unsigned SplitW = $clog2(MAX_SPLIT + 2);

  mst_state_e        state_q, state_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [SplitW-1:0] split_cnt_q, split_cnt_d;
  logic              hbusreq_q, hbusreq_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timer_clr, timer_en, timer_term;

  ahb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk  (hclk),
    .rst_n(hresetn),
    .clr  (timer_clr),
    .en   (timer_en),
    .term (timer_term)
  );

  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    split_cnt_d = split_cnt_q;
    hbusreq_d   = hbusreq_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cmd_write_d = bus.req_write;
          cmd_addr_d  = bus.req_addr;
          cmd_wdata_d = bus.req_wdata;
          split_cnt_d = '0;
          hbusreq_d   = 1'b1;
          state_d     = StBusreq;
        end
      end
      StBusreq: begin
        if (bus.hgrant && bus.hready) begin
          haddr_d  = cmd_addr_q;
          hwrite_d = cmd_write_q;
          htrans_d = HTRANS_NONSEQ;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (bus.hready) begin
          htrans_d  = HTRANS_IDLE;
          hbusreq_d = 1'b0;
          if (cmd_write_q) hwdata_d = cmd_wdata_q;
          timer_clr = 1'b1;
          state_d   = StData;
        end
      end
      StData: begin
        if (bus.hsplit) begin
          split_cnt_d = split_cnt_q + SplitW'(1);
          state_d     = StSplitWait;
        end else if (bus.hready && (bus.hresp == HRESP_ERROR)) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (bus.hready) begin
          rsp_err_d   = 1'b0;
          if (!cmd_write_q) rsp_rdata_d = bus.hrdata;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          timer_en = 1'b1;
          if (timer_term) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StSplitWait: begin
        hbusreq_d = 1'b0;
        htrans_d  = HTRANS_IDLE;
        if (split_cnt_q > SplitW'(MAX_SPLIT)) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (bus.hsplit_done) begin
          hbusreq_d = 1'b1;
          state_d   = StBusreq;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= StIdle;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      split_cnt_q <= '0;
      hbusreq_q   <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      split_cnt_q <= split_cnt_d;
      hbusreq_q   <= hbusreq_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.hbusreq   = hbusreq_q;
  assign bus.haddr     = haddr_q;
  assign bus.htrans    = htrans_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: stimulus pushes expected responses,
// a negedge monitor pops and compares them when rsp_valid pulses.
module tb_ahb_master_if;
  import ahb_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          at;
  } exp_t;

  logic hclk;
  logic hresetn;
  int   total;
  int   bad;
  int   cyc;
  exp_t q[$];

  ahb_master_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_if #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .TIMEOUT  (16),
    .MAX_SPLIT(3)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge hclk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Handshake one command; returns 1 ns after the accepting edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
    chk("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    chk("hbusreq_after_accept", bus.hbusreq, 1'b1);
  endtask

  // lat: edges from accept to the edge that raises rsp_valid; <0 means unchecked.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd, input bit chk_rd,
                       input int lat);
    exp_t e;
    e.err       = e_err;
    e.rdata     = e_rd;
    e.chk_rdata = chk_rd;
    e.at        = (lat < 0) ? -1 : cyc + 1 + lat;
    q.push_back(e);
    send(wr, a, d);
  endtask

  task automatic wait_nonseq(input string name);
    int i = 0;
    while (bus.htrans !== HTRANS_NONSEQ && i < 50) begin
      tick();
      i++;
    end
    chk(name, bus.htrans, HTRANS_NONSEQ);
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (q.size() != 0 && i < 60) begin
      tick();
      i++;
    end
    chk(name, q.size(), 0);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (hresetn && bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("rsp_err", bus.rsp_err, e.err);
          if (e.chk_rdata) chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          if (e.at >= 0) chk("rsp_latency", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    total           = 0;
    bad             = 0;
    hresetn         = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.hgrant      = 1'b1;
    bus.hready      = 1'b1;
    bus.hresp       = 1'b0;
    bus.hrdata      = '0;
    bus.hsplit      = 1'b0;
    bus.hsplit_done = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_hbusreq", bus.hbusreq, 1'b0);
    chk("rst_htrans", bus.htrans, HTRANS_IDLE);
    chk("rst_haddr", bus.haddr, 32'h0);
    chk("rst_hwrite", bus.hwrite, 1'b0);
    chk("rst_hwdata", bus.hwdata, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    hresetn = 1'b1;
    tick();

    // Write, zero wait: RESP is the 4th cycle after the accept cycle
    issue(1'b1, 32'h05, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 3);
    chk("t1_req_ready_busy", bus.req_ready, 1'b0);
    tick();
    chk("t1_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("t1_haddr", bus.haddr, 32'h05);
    chk("t1_hwrite", bus.hwrite, 1'b1);
    tick();
    chk("t1_htrans_idle", bus.htrans, HTRANS_IDLE);
    chk("t1_hwdata", bus.hwdata, 32'hDEADBEEF);
    chk("t1_hbusreq_low", bus.hbusreq, 1'b0);
    wait_drain("t1_drain");

    // Read with 3 data-phase wait states
    issue(1'b0, 32'h02, 32'h0, 1'b0, 32'h3, 1'b1, 6);
    tick();
    chk("t2_haddr", bus.haddr, 32'h02);
    chk("t2_hwrite", bus.hwrite, 1'b0);
    tick();
    bus.hready = 1'b0;
    repeat (3) tick();
    bus.hready = 1'b1;
    bus.hrdata = 32'h3;
    wait_drain("t2_drain");

    // Slave ERROR response
    issue(1'b1, 32'h01, 32'h1234, 1'b1, 32'h0, 1'b0, 3);
    tick();
    tick();
    bus.hresp = 1'b1;
    tick();
    bus.hresp = 1'b0;
    chk("t3_bus_idle", bus.htrans, HTRANS_IDLE);
    wait_drain("t3_drain");
    chk("t3_single_pulse", bus.rsp_valid, 1'b0);

    // Split then resume 7 cycles later; same command reissued
    issue(1'b0, 32'h04, 32'h0, 1'b0, 32'h5, 1'b1, -1);
    wait_nonseq("t4_nonseq1");
    chk("t4_haddr1", bus.haddr, 32'h04);
    bus.hsplit = 1'b1;
    tick();
    tick();
    bus.hsplit = 1'b0;
    chk("t4_hbusreq_drop", bus.hbusreq, 1'b0);
    chk("t4_htrans_idle", bus.htrans, HTRANS_IDLE);
    repeat (6) tick();
    bus.hsplit_done = 1'b1;
    tick();
    bus.hsplit_done = 1'b0;
    chk("t4_hbusreq_again", bus.hbusreq, 1'b1);
    bus.hrdata = 32'h5;
    wait_nonseq("t4_nonseq2");
    chk("t4_haddr2", bus.haddr, 32'h04);
    chk("t4_hwrite2", bus.hwrite, 1'b0);
    wait_drain("t4_drain");

    // Four splits exhaust the retry budget
    issue(1'b0, 32'h08, 32'h0, 1'b1, 32'h0, 1'b0, -1);
    for (int k = 0; k < 4; k++) begin
      wait_nonseq("t5_nonseq");
      bus.hsplit = 1'b1;
      tick();
      tick();
      bus.hsplit = 1'b0;
      if (k < 3) begin
        repeat (2) tick();
        bus.hsplit_done = 1'b1;
        tick();
        bus.hsplit_done = 1'b0;
      end
    end
    wait_drain("t5_drain");
    chk("t5_hbusreq_low", bus.hbusreq, 1'b0);

    // Data-phase timeout after 16 stalled cycles
    issue(1'b1, 32'h10, 32'h55, 1'b1, 32'h0, 1'b0, 18);
    tick();
    tick();
    bus.hready = 1'b0;
    repeat (5) tick();
    chk("t6_hwdata_held", bus.hwdata, 32'h55);
    wait_drain("t6_drain");
    bus.hready = 1'b1;

    // Reset during the data phase drops the command
    send(1'b0, 32'h20, 32'h0);
    tick();
    tick();
    bus.hready = 1'b0;
    repeat (3) tick();
    hresetn = 1'b0;
    #1;
    chk("t7_htrans", bus.htrans, HTRANS_IDLE);
    chk("t7_hbusreq", bus.hbusreq, 1'b0);
    chk("t7_rsp_valid", bus.rsp_valid, 1'b0);
    chk("t7_haddr", bus.haddr, 32'h0);
    chk("t7_req_ready_rst", bus.req_ready, 1'b1);
    bus.hready = 1'b1;
    repeat (2) tick();
    hresetn = 1'b1;
    tick();
    chk("t7_req_ready", bus.req_ready, 1'b1);
    repeat (8) tick();

    // Resume pulse while idle is ignored; then a clean read
    bus.hsplit_done = 1'b1;
    tick();
    bus.hsplit_done = 1'b0;
    chk("t8_idle_hbusreq", bus.hbusreq, 1'b0);
    bus.hrdata = 32'hA5A50001;
    issue(1'b0, 32'h30, 32'h0, 1'b0, 32'hA5A50001, 1'b1, 3);
    wait_drain("t8_drain");

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
